// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: load encodings, FSM states and register-file constants shared by the write-back stage.
package wb_stage_pkg;
  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4
  } ld_type_e;
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;
  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [31:0] LINK_OFFSET = 32'd8;
endpackage

// File: rtl/wb_stage_load_extend.sv
// load_extend: selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module load_extend
  import wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ld_type,
  output logic [31:0] value
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = rdata[{addr_lo[1], 4'b0000} +: 16];
    value = ld_type == LD_LB  ? {{24{b[7]}}, b} :
            ld_type == LD_LBU ? {24'b0, b} :
            ld_type == LD_LH  ? {{16{h[15]}}, h} :
            ld_type == LD_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back sequencer; retires MEM-stage instructions and waits for loads before driving the register file.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [4:0]  in_wreg,
  input  logic [31:0] in_result,
  input  logic [31:0] in_pc,
  input  logic        in_is_link,
  input  logic        in_is_load,
  input  logic [2:0]  in_ld_type,
  input  logic [1:0]  in_addr_lo,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  output logic        RegWrite,
  output logic        store_pc,
  output logic [31:0] inst_address,
  output logic        stall,
  output logic        ld_timeout,
  output logic        r31_drop
);
  state_e state, state_nx;
  logic [TO_W-1:0] cnt;
  logic l_wen;
  logic [4:0] l_wreg;
  logic [2:0] l_type;
  logic [1:0] l_lo;
  logic [31:0] ext, w_val;
  logic [4:0] w_reg;
  logic accept, do_alu, ld_done, expire, wr_go, w_link, spc, rw, r31_hit;

  load_extend u_ext (
    .rdata   (dmem_rdata),
    .addr_lo (l_lo),
    .ld_type (l_type),
    .value   (ext)
  );

  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_nx;

  always_comb begin
    accept = in_valid && in_ready;
    ld_done = state == S_WAIT && dmem_rvalid;
    expire = state == S_WAIT && !dmem_rvalid && cnt <= TO_W'(1);
    state_nx = state == S_IDLE ? (accept && in_is_load ? S_WAIT : S_IDLE)
                               : (ld_done || expire ? S_IDLE : S_WAIT);
  end

  always_comb begin
    in_ready = state == S_IDLE && !rst;
    stall = !in_ready;
  end

  // A link to $31 becomes store_pc; every other qualifying write becomes RegWrite.
  always_comb begin
    do_alu = accept && !in_is_load;
    wr_go = (do_alu && in_wen && in_wreg != 5'd0) || (ld_done && l_wen && l_wreg != 5'd0);
    w_reg = do_alu ? in_wreg : l_wreg;
    w_link = do_alu && in_is_link;
    w_val = w_link ? in_pc + LINK_OFFSET : do_alu ? in_result : ext;
    spc = wr_go && w_link && w_reg == REG_RA;
    rw = wr_go && !spc;
    r31_hit = rw && !w_link && w_reg == REG_RA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wreg <= '0;
      wdata <= '0;
      inst_address <= '0;
      RegWrite <= 1'b0;
      store_pc <= 1'b0;
      ld_timeout <= 1'b0;
      r31_drop <= 1'b0;
      cnt <= '0;
      l_wen <= 1'b0;
      l_wreg <= '0;
      l_type <= '0;
      l_lo <= '0;
    end else begin
      RegWrite <= rw;
      store_pc <= spc;
      if (rw) begin
        wreg <= w_reg;
        wdata <= w_val;
      end
      if (spc) inst_address <= in_pc;
      if (r31_hit) r31_drop <= 1'b1;
      if (expire) ld_timeout <= 1'b1;
      if (accept && in_is_load) begin
        l_wen <= in_wen;
        l_wreg <= in_wreg;
        l_type <= in_ld_type;
        l_lo <= in_addr_lo;
        cnt <= TO_W'(LOAD_TIMEOUT);
      end else if (state == S_WAIT && !dmem_rvalid) begin
        cnt <= cnt - TO_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of wb_stage with a default-timeout instance and a short-timeout instance.
module tb_wb_stage;
  logic clk = 0, rst = 1, valid = 0, sel_t = 0;
  logic in_wen = 0, in_is_link = 0, in_is_load = 0, dmem_rvalid = 0;
  logic [4:0] in_wreg = 0;
  logic [31:0] in_result = 0, in_pc = 0, dmem_rdata = 0;
  logic [2:0] in_ld_type = 0;
  logic [1:0] in_addr_lo = 0;
  logic in_ready, RegWrite, store_pc, stall, ld_timeout, r31_drop;
  logic [4:0] wreg;
  logic [31:0] wdata, inst_address;
  logic in_ready_t, RegWrite_t, store_pc_t, stall_t, ld_timeout_t, r31_drop_t;
  logic [4:0] wreg_t;
  logic [31:0] wdata_t, inst_address_t;
  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(valid && !sel_t), .in_ready(in_ready),
    .in_wen(in_wen), .in_wreg(in_wreg), .in_result(in_result), .in_pc(in_pc),
    .in_is_link(in_is_link), .in_is_load(in_is_load), .in_ld_type(in_ld_type),
    .in_addr_lo(in_addr_lo), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wreg(wreg), .wdata(wdata), .RegWrite(RegWrite), .store_pc(store_pc),
    .inst_address(inst_address), .stall(stall), .ld_timeout(ld_timeout), .r31_drop(r31_drop)
  );

  wb_stage #(.LOAD_TIMEOUT(3)) dut_t (
    .clk(clk), .rst(rst), .in_valid(valid && sel_t), .in_ready(in_ready_t),
    .in_wen(in_wen), .in_wreg(in_wreg), .in_result(in_result), .in_pc(in_pc),
    .in_is_link(in_is_link), .in_is_load(in_is_load), .in_ld_type(in_ld_type),
    .in_addr_lo(in_addr_lo), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wreg(wreg_t), .wdata(wdata_t), .RegWrite(RegWrite_t), .store_pc(store_pc_t),
    .inst_address(inst_address_t), .stall(stall_t), .ld_timeout(ld_timeout_t), .r31_drop(r31_drop_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic wen, input logic [4:0] r, input logic [31:0] res,
                       input logic [31:0] pc, input logic link, input logic ld);
    valid = v; in_wen = wen; in_wreg = r; in_result = res; in_pc = pc; in_is_link = link; in_is_load = ld;
  endtask

  task automatic do_load(input string tag, input logic [2:0] t, input logic [1:0] lo,
                         input logic [31:0] rd, input logic [31:0] exp);
    drive(1, 1, 5'd6, 0, 0, 0, 1);
    in_ld_type = t; in_addr_lo = lo;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk({tag, "_stall0"}, 32'(stall), 1);
    chk({tag, "_nowr"}, 32'(RegWrite), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_stall"}, 32'(stall), 1);
    end
    dmem_rvalid = 1; dmem_rdata = rd;
    tick();
    dmem_rvalid = 0;
    chk({tag, "_rw"}, 32'(RegWrite), 1);
    chk({tag, "_wreg"}, 32'(wreg), 6);
    chk({tag, "_wdata"}, wdata, exp);
    chk({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    tick();
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_stall", 32'(stall), 1);
    chk("rst_rw", 32'(RegWrite), 0);
    chk("rst_spc", 32'(store_pc), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ia", inst_address, 0);
    rst = 0;
    #1;
    chk("idle_ready", 32'(in_ready), 1);

    drive(1, 1, 5'd2, 32'h11, 0, 0, 0);
    tick();
    chk("b2b1_rw", 32'(RegWrite), 1);
    chk("b2b1_wreg", 32'(wreg), 2);
    chk("b2b1_wdata", wdata, 32'h11);
    chk("b2b1_ready", 32'(in_ready), 1);
    drive(1, 1, 5'd3, 32'h22, 0, 0, 0);
    tick();
    chk("b2b2_rw", 32'(RegWrite), 1);
    chk("b2b2_wdata", wdata, 32'h22);
    chk("b2b2_ready", 32'(in_ready), 1);
    drive(1, 1, 5'd4, 32'h33, 0, 0, 0);
    tick();
    chk("b2b3_rw", 32'(RegWrite), 1);
    chk("b2b3_wreg", 32'(wreg), 4);
    chk("b2b3_wdata", wdata, 32'h33);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("b2b_end_rw", 32'(RegWrite), 0);
    chk("b2b_hold", wdata, 32'h33);

    drive(1, 1, 5'd31, 32'hDEAD, 32'h0040_0010, 1, 0);
    tick();
    chk("jal_spc", 32'(store_pc), 1);
    chk("jal_rw", 32'(RegWrite), 0);
    chk("jal_ia", inst_address, 32'h0040_0010);
    drive(1, 1, 5'd5, 32'hDEAD, 32'h0040_0020, 1, 0);
    tick();
    chk("jalr_rw", 32'(RegWrite), 1);
    chk("jalr_spc", 32'(store_pc), 0);
    chk("jalr_wreg", 32'(wreg), 5);
    chk("jalr_wdata", wdata, 32'h0040_0028);
    chk("jalr_ia_hold", inst_address, 32'h0040_0010);
    drive(1, 1, 5'd7, 0, 32'hFFFF_FFFC, 1, 0);
    tick();
    chk("link_wrap", wdata, 32'h0000_0004);
    drive(0, 0, 0, 0, 0, 0, 0);

    do_load("lb", 3'd0, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'd1, 2'd3, 32'h80FF_0000, 32'h0000_0080);
    do_load("lh", 3'd2, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF);
    do_load("lhu", 3'd3, 2'd3, 32'h80FF_1234, 32'h0000_80FF);
    do_load("lw", 3'd6, 2'd1, 32'hCAFE_BABE, 32'hCAFE_BABE);

    dmem_rvalid = 1; dmem_rdata = 32'h5555_5555;
    tick();
    dmem_rvalid = 0;
    chk("idle_rvalid_ign", 32'(RegWrite), 0);

    sel_t = 1;
    drive(1, 1, 5'd8, 0, 0, 0, 1);
    in_ld_type = 3'd4; in_addr_lo = 0;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("to_stall", 32'(stall_t), 1);
      chk("to_flag_low", 32'(ld_timeout_t), 0);
      tick();
    end
    chk("to_flag", 32'(ld_timeout_t), 1);
    chk("to_nowr", 32'(RegWrite_t), 0);
    chk("to_ready", 32'(in_ready_t), 1);
    drive(1, 1, 5'd7, 32'h77, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("to_next_rw", 32'(RegWrite_t), 1);
    chk("to_next_wdata", wdata_t, 32'h77);
    chk("to_sticky", 32'(ld_timeout_t), 1);

    rst = 1;
    tick();
    rst = 0;
    chk("to_rst_clear", 32'(ld_timeout_t), 0);
    drive(1, 1, 5'd9, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 0;
    chk("exp_rw", 32'(RegWrite_t), 1);
    chk("exp_wdata", wdata_t, 32'h1234_5678);
    chk("exp_no_to", 32'(ld_timeout_t), 0);
    sel_t = 0;

    drive(1, 1, 5'd10, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rstw_stall", 32'(stall), 1);
    rst = 1;
    tick();
    chk("rstw_ready", 32'(in_ready), 0);
    chk("rstw_rw", 32'(RegWrite), 0);
    chk("rstw_wreg", 32'(wreg), 0);
    chk("rstw_wdata", wdata, 0);
    chk("rstw_ia", inst_address, 0);
    rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 0;
    chk("rstw_drop", 32'(RegWrite), 0);
    chk("rstw_ready2", 32'(in_ready), 1);

    drive(1, 1, 5'd31, 32'hAB, 0, 0, 0);
    tick();
    chk("r31_rw", 32'(RegWrite), 1);
    chk("r31_flag", 32'(r31_drop), 1);
    chk("r31_spc", 32'(store_pc), 0);
    drive(1, 1, 5'd0, 32'hCD, 0, 0, 0);
    tick();
    chk("r0_rw", 32'(RegWrite), 0);
    chk("r0_spc", 32'(store_pc), 0);
    chk("r0_hold", wdata, 32'hAB);
    drive(1, 0, 5'd12, 32'hEE, 0, 0, 0);
    tick();
    chk("nowen_rw", 32'(RegWrite), 0);
    chk("nowen_ready", 32'(in_ready), 1);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back sequencer on the writer side of the register file write port. It is the sole driver of wreg, wdata, RegWrite, store_pc and inst_address.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- Waits for data-memory load responses, then aligns and extends the load data.
- Converts link writes into the register file's two write mechanisms: store_pc for $31, RegWrite for any other rd.

Parameters:
- LOAD_TIMEOUT, 255: maximum cycles spent in WAIT_LOAD before the load is abandoned; range 1..255.
- TO_W, 8: width of the timeout counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  high in IDLE only.
- in_wen  in  1  instruction writes a GPR.
- in_wreg  in  5  destination register.
- in_result  in  32  ALU result.
- in_pc  in  32  instruction address.
- in_is_link  in  1  jal/jalr/bltzal-class link write.
- in_is_load  in  1  value comes from data memory.
- in_ld_type  in  3  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW; 5..7 treated as LW.
- in_addr_lo  in  2  load address bits [1:0].
- dmem_rvalid  in  1  load data valid, single-cycle pulse.
- dmem_rdata  in  32  load data, word-aligned, little-endian.
- wreg  out  5  to register file.
- wdata  out  32  to register file.
- RegWrite  out  1  to register file; one-cycle pulse.
- store_pc  out  1  to register file; one-cycle pulse.
- inst_address  out  32  to register file; register file computes the $31 value as inst_address+8.
- stall  out  1  equals ~in_ready.
- ld_timeout  out  1  sticky; set when a load is abandoned.
- r31_drop  out  1  sticky; set when a non-link write targets $31.

Behaviour:
- Reset: state IDLE, all outputs and internal registers 0, in_ready 0 during the reset cycle. Reset during WAIT_LOAD discards the pending load with no write.
- All register-file outputs are registered.
- RegWrite and store_pc are never both high. Each is high for exactly one cycle per retired instruction.
- IDLE, handshake with in_valid & in_ready and in_is_load=0:
  - The write appears on the next cycle.
  - Throughput is one instruction per cycle, back-to-back.
- IDLE, handshake with in_is_load=1:
  - Capture in_wen, in_wreg, in_ld_type and in_addr_lo; load the counter with LOAD_TIMEOUT; go to WAIT_LOAD.
  - No write is issued.
- WAIT_LOAD:
  - in_ready is 0.
  - On dmem_rvalid: extend the data and write it the next cycle (if captured in_wen=1 and wreg!=0); return to IDLE.
  - Without dmem_rvalid: the counter decrements. When the counter reaches 0 with no rvalid, set ld_timeout, issue no write, return to IDLE.
  - rvalid in the same cycle as expiry: the data wins.
- dmem_rvalid in IDLE is ignored.
- Extension rules:
  - byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored for halfword loads.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- Write routing:
  - in_wen=0 or in_wreg=0: no pulse; the instruction is still consumed.
  - is_link and wreg=31: store_pc=1, inst_address=in_pc, RegWrite=0.
  - is_link and wreg not in {0,31}: RegWrite=1, wdata=in_pc+8 (wraps mod 2^32).
  - Non-link and wreg not in {0,31}: RegWrite=1, wdata=result or extended load data.
  - Non-link and wreg=31: RegWrite=1 still driven (the register file drops it); r31_drop set.
- When no pulse is issued, wreg, wdata and inst_address hold their previous values.

Decomposition:
- Shared package: LD_LB..LD_LW encodings, REG_RA=5'd31, LINK_OFFSET=32'd8.
- One sub-module, load_extend: combinational rdata/addr_lo/ld_type to 32-bit value; reused by any future load path.

Test Plan:
- Three back-to-back ALU writes to r2, r3, r4 with in_result 0x11, 0x22, 0x33 -> RegWrite high for 3 consecutive cycles starting 1 cycle after first accept; wdata 0x11, 0x22, 0x33; in_ready stays 1.
- jal with pc=0x00400010, wreg=31 -> store_pc pulse, inst_address=0x00400010, RegWrite 0. jalr with rd=5, pc=0x00400020 -> RegWrite, wreg=5, wdata=0x00400028.
- LB addr_lo=3, rdata=0x80FF_0000, rvalid 4 cycles after accept -> stall high for 4 cycles; write 0xFFFFFF80 one cycle after rvalid. Repeat as LBU -> 0x00000080. LH addr_lo=2 -> 0xFFFF80FF.
- LOAD_TIMEOUT=3, no rvalid -> ld_timeout set, no write, in_ready returns, next ALU op retires normally. Second run: rvalid exactly on expiry cycle -> write occurs, ld_timeout stays 0.
- rst asserted in WAIT_LOAD, then rvalid -> no write; all outputs 0 during reset.
- Non-link write to r31 -> r31_drop set. Write to r0 -> no pulse.
